// File: rtl/lockout_pkg.sv
// Shared definitions for the lockout guard.
// Contents:
//    ST_IDLE / ST_COUNTING / ST_LOCKED  state encoding of the guard FSM
//    ESC_MAX                            highest escalation level
//    sat_shift()                        base << sh, clamped to max_val
// Optional feature macro used by the guard: LOCKOUT_ESCALATE_EN.
package lockout_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COUNTING = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   localparam logic [1:0] ESC_MAX = 2'd3;

   // Lockout length for a given escalation level. 16 bits is enough for
   // any legal LOCK_SEC (<= 63) shifted by up to 3; the caller truncates
   // to its counter width after the clamp.
   function automatic logic [15:0] sat_shift(input logic [15:0] base,
                                             input logic [1:0]  sh,
                                             input logic [15:0] max_val);
      logic [15:0] v;
      v = base << sh;
      return (v > max_val) ? max_val : v;
   endfunction

endpackage

// File: rtl/lockout_guard_rise_edge.sv
// Registered rising-edge detector.
// Ports:
//    clk    in   system clock
//    rst    in   asynchronous active-low reset
//    lvl    in   level to watch
//    rise   out  one-clk pulse, one cycle after lvl goes 0 -> 1
// A level held high for any number of cycles gives exactly one pulse.
module rise_edge (
   input  logic clk,
   input  logic rst,
   input  logic lvl,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         prev_q <= lvl;
         rise   <= lvl & ~prev_q;
      end
   end

endmodule

// File: rtl/lockout_guard.sv
// Brute-force guard between the password-compare FSM and the
// indicator/countdown stages. Counts consecutive failed entries; after
// MAX_FAILS failures it locks the keypad out for a timed number of seconds.
// Optional feature: define LOCKOUT_ESCALATE_EN to double the lockout length
// on each consecutive lockout (clamped to 2^SEC_W-1, at most 3 doublings).
// Ports:
//    clk         in   system clock
//    rst         in   asynchronous active-low reset
//    tick_1hz    in   one-clk enable, once per second
//    pass_lvl    in   FSM "password matched" level
//    fail_lvl    in   FSM "password mismatched" level
//    admin_clr   in   synchronous clear, overrides everything else
//    key_block   out  suppress keypad enable into the FSM
//    locked      out  high while locked out
//    fail_cnt    out  consecutive-failure count
//    remain_sec  out  lockout seconds remaining, 0 when not locked
//    lock_pulse  out  one-clk strobe on lockout entry
//    state_dbg   out  current FSM state (lockout_pkg encoding)
// Handshake note: there is no valid/ready pair; pass/fail are levels whose
// rising edges are events, tick_1hz and admin_clr are sampled every clock.
module lockout_guard
   import lockout_pkg::*;
#(
   parameter int MAX_FAILS = 3,
   parameter int LOCK_SEC  = 30,
   parameter int SEC_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1hz,
   input  logic             pass_lvl,
   input  logic             fail_lvl,
   input  logic             admin_clr,
   output logic             key_block,
   output logic             locked,
   output logic [3:0]       fail_cnt,
   output logic [SEC_W-1:0] remain_sec,
   output logic             lock_pulse,
   output logic [1:0]       state_dbg
);

   localparam logic [3:0]  MAX_CNT  = 4'(MAX_FAILS);
   localparam logic [15:0] BASE_LEN = 16'(LOCK_SEC);
   localparam logic [15:0] SEC_MAX  = 16'((1 << SEC_W) - 1);

   logic pass_rise, fail_rise;

   rise_edge u_pass_edge (
      .clk  (clk),
      .rst  (rst),
      .lvl  (pass_lvl),
      .rise (pass_rise)
   );

   rise_edge u_fail_edge (
      .clk  (clk),
      .rst  (rst),
      .lvl  (fail_lvl),
      .rise (fail_rise)
   );

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [SEC_W-1:0] remain_q, remain_d;
   logic             pulse_q, pulse_d;
   logic [3:0]       cnt_inc;
   logic [15:0]      len_full;
   logic [SEC_W-1:0] lock_len;

`ifdef LOCKOUT_ESCALATE_EN
   logic [1:0] esc_q, esc_d;
   assign len_full = sat_shift(BASE_LEN, esc_q, SEC_MAX);
`else
   assign len_full = sat_shift(BASE_LEN, 2'd0, SEC_MAX);
`endif

   assign lock_len = len_full[SEC_W-1:0];
   assign cnt_inc  = cnt_q + 4'd1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         remain_q <= '0;
         pulse_q  <= 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
         esc_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         remain_q <= remain_d;
         pulse_q  <= pulse_d;
`ifdef LOCKOUT_ESCALATE_EN
         esc_q    <= esc_d;
`endif
      end
   end

   // Next-state logic: priority is admin_clr, then lockout countdown, then
   // fail edge, then pass edge (a simultaneous pass is dropped).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      pulse_d  = 1'b0;
`ifdef LOCKOUT_ESCALATE_EN
      esc_d    = esc_q;
`endif
      if (admin_clr) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         remain_d = '0;
`ifdef LOCKOUT_ESCALATE_EN
         esc_d    = '0;
`endif
      end else begin
         case (state_q)
            ST_LOCKED: begin
               // Edges are ignored here; only the seconds tick matters.
               if (tick_1hz && (remain_q != '0)) begin
                  remain_d = remain_q - 1'b1;
                  if (remain_q == SEC_W'(1)) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end
               end
            end
            default: begin
               if (fail_rise) begin
                  if (cnt_inc == MAX_CNT) begin
                     // A tick in this same cycle is deliberately not applied.
                     state_d  = ST_LOCKED;
                     cnt_d    = MAX_CNT;
                     remain_d = lock_len;
                     pulse_d  = 1'b1;
`ifdef LOCKOUT_ESCALATE_EN
                     if (esc_q != ESC_MAX) esc_d = esc_q + 2'd1;
`endif
                  end else begin
                     state_d = ST_COUNTING;
                     cnt_d   = cnt_inc;
                  end
               end else if (pass_rise) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
`ifdef LOCKOUT_ESCALATE_EN
                  esc_d   = '0;
`endif
               end
            end
         endcase
      end
   end

   // Outputs are taken straight from registers.
   always_comb begin
      key_block  = (state_q == ST_LOCKED);
      locked     = (state_q == ST_LOCKED);
      fail_cnt   = cnt_q;
      remain_sec = remain_q;
      lock_pulse = pulse_q;
      state_dbg  = state_q;
   end

endmodule

// File: tb/tb_lockout_guard.sv
// Bench for lockout_guard: directed scenarios followed by random stimulus,
// all checked cycle by cycle against a behavioural model through an
// expected-output queue, plus a handful of direct value checks.
module tb_lockout_guard;

   localparam int MAX_FAILS = 3;
   localparam int LOCK_SEC  = 30;
   localparam int SEC_W     = 6;
   localparam int SEC_MAXV  = (1 << SEC_W) - 1;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic             tick_1hz = 1'b0;
   logic             pass_lvl = 1'b0;
   logic             fail_lvl = 1'b0;
   logic             admin_clr = 1'b0;
   logic             key_block;
   logic             locked;
   logic [3:0]       fail_cnt;
   logic [SEC_W-1:0] remain_sec;
   logic             lock_pulse;
   logic [1:0]       state_dbg;

   lockout_guard #(
      .MAX_FAILS (MAX_FAILS),
      .LOCK_SEC  (LOCK_SEC),
      .SEC_W     (SEC_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1hz   (tick_1hz),
      .pass_lvl   (pass_lvl),
      .fail_lvl   (fail_lvl),
      .admin_clr  (admin_clr),
      .key_block  (key_block),
      .locked     (locked),
      .fail_cnt   (fail_cnt),
      .remain_sec (remain_sec),
      .lock_pulse (lock_pulse),
      .state_dbg  (state_dbg)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cycle = 0;

   // Behavioural reference: the guard in terms of events and seconds.
   bit m_locked, m_pulse;
   int m_cnt, m_remain, m_esc;
   bit m_prev_pass, m_prev_fail, m_pend_pass, m_pend_fail;

   logic [12:0] exp_q[$];

   function automatic int lock_len_of(int esc);
      int l;
      l = LOCK_SEC;
`ifdef LOCKOUT_ESCALATE_EN
      l = LOCK_SEC * (2 ** esc);
`endif
      if (l > SEC_MAXV) l = SEC_MAXV;
      return l;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_pulse = 0; m_cnt = 0; m_remain = 0; m_esc = 0;
      m_prev_pass = 0; m_prev_fail = 0; m_pend_pass = 0; m_pend_fail = 0;
   endtask

   // One clock of the reference, using the inputs about to be sampled.
   // Edges seen on the levels take effect one clock later.
   task automatic model_step(bit tk, bit p, bit f, bit adm);
      logic [12:0] e;
      m_pulse = 0;
      if (adm) begin
         m_locked = 0; m_cnt = 0; m_remain = 0; m_esc = 0;
      end else if (m_locked) begin
         if (tk && m_remain > 0) begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin
               m_locked = 0;
               m_cnt = 0;
            end
         end
      end else if (m_pend_fail) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == MAX_FAILS) begin
            m_locked = 1;
            m_remain = lock_len_of(m_esc);
            m_pulse = 1;
            if (m_esc < 3) m_esc = m_esc + 1;
         end
      end else if (m_pend_pass) begin
         m_cnt = 0;
         m_esc = 0;
      end
      m_pend_fail = f && !m_prev_fail;
      m_pend_pass = p && !m_prev_pass;
      m_prev_fail = f;
      m_prev_pass = p;
      e = {m_locked, m_locked, 4'(m_cnt), 6'(m_remain), m_pulse};
      exp_q.push_back(e);
   endtask

   // Driver tasks
   task automatic drive(bit tk, bit p, bit f, bit adm);
      @(negedge clk);
      tick_1hz = tk; pass_lvl = p; fail_lvl = f; admin_clr = adm;
      model_step(tk, p, f, adm);
   endtask

   task automatic hold(bit tk, bit p, bit f, bit adm, int n);
      for (int i = 0; i < n; i++) drive(tk, p, f, adm);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, int act, int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_edges(int n);
      for (int i = 0; i < n; i++) begin
         hold(0, 0, 1, 0, 3);
         hold(0, 0, 0, 0, 2);
      end
   endtask

   task automatic tick_until(int target, int budget);
      int k;
      k = 0;
      while (m_remain != target && k < budget) begin
         drive(1, 0, 0, 0);
         k++;
      end
      if (m_remain != target) chk("tick_budget", m_remain, target);
   endtask

   // Monitor: one expected entry per clock while out of reset.
   always @(posedge clk) begin
      logic [12:0] got, exp;
      #1;
      cycle++;
      if (rst && exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {key_block, locked, fail_cnt, remain_sec, lock_pulse};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL outputs cycle %0d: got kb=%0b lk=%0b cnt=%0d rem=%0d pl=%0b expected kb=%0b lk=%0b cnt=%0d rem=%0d pl=%0b",
                     cycle, got[12], got[11], got[10:7], got[6:1], got[0],
                     exp[12], exp[11], exp[10:7], exp[6:1], exp[0]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int exp_len[4];

   initial begin
      model_reset();
      #1;
      chk("reset_key_block", key_block, 0);
      chk("reset_locked", locked, 0);
      chk("reset_fail_cnt", fail_cnt, 0);
      chk("reset_remain", remain_sec, 0);
      chk("reset_pulse", lock_pulse, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Three held fail levels count once each and lock the keypad.
      hold(0, 0, 1, 0, 5);
      settle(); chk("cnt_after_1", fail_cnt, 1);
      hold(0, 0, 0, 0, 2);
      hold(0, 0, 1, 0, 5);
      settle(); chk("cnt_after_2", fail_cnt, 2);
      hold(0, 0, 0, 0, 2);
      hold(0, 0, 1, 0, 5);
      settle(); chk("lock_locked", locked, 1);
      chk("lock_remain", remain_sec, LOCK_SEC);
      chk("lock_cnt", fail_cnt, MAX_FAILS);

      // Countdown with pass/fail edges mixed into the first seconds.
      for (int i = 0; i < 30; i++)
         drive(1, (i < 10) && (i % 4 == 1), (i < 10) && (i % 4 == 3), 0);
      hold(0, 0, 0, 0, 2);
      settle();
      chk("expire_locked", locked, 0);
      chk("expire_remain", remain_sec, 0);
      chk("expire_cnt", fail_cnt, 0);

      // Two fails then a pass.
      fail_edges(2);
      hold(0, 1, 0, 0, 3);
      hold(0, 0, 0, 0, 2);
      settle(); chk("pass_clears_cnt", fail_cnt, 0);
      chk("pass_not_locked", locked, 0);

      // Same-clock pass+fail at count 2, with a tick in the entry clock.
      fail_edges(2);
      drive(0, 1, 1, 0);
      drive(1, 1, 1, 0);
      settle();
      chk("samedge_locked", locked, 1);
      chk("entry_tick_remain", remain_sec, lock_len_of(0));
      hold(0, 0, 0, 0, 1);

      // admin_clr in the middle of a lockout.
      tick_until(12, 80);
      drive(0, 0, 0, 1);
      settle();
      chk("admin_remain", remain_sec, 0);
      chk("admin_key_block", key_block, 0);
      chk("admin_cnt", fail_cnt, 0);
      hold(0, 0, 0, 0, 1);

      // Asynchronous reset in the middle of a lockout.
      fail_edges(3);
      tick_until(7, 80);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_key_block", key_block, 0);
      chk("arst_remain", remain_sec, 0);
      chk("arst_cnt", fail_cnt, 0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Back-to-back lockouts, then a pass and one more.
`ifdef LOCKOUT_ESCALATE_EN
      exp_len = '{30, 60, 63, 30};
`else
      exp_len = '{30, 30, 30, 30};
`endif
      for (int n = 0; n < 4; n++) begin
         if (n == 3) begin
            hold(0, 1, 0, 0, 3);
            hold(0, 0, 0, 0, 2);
         end
         fail_edges(2);
         hold(0, 0, 1, 0, 2);
         settle();
         chk($sformatf("lock_len_%0d", n), remain_sec, exp_len[n]);
         hold(0, 0, 0, 0, 1);
         tick_until(0, 100);
         hold(0, 0, 0, 0, 1);
      end

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 2) == 0,
               ($urandom_range(0, 9) == 0) ? !pass_lvl : pass_lvl,
               ($urandom_range(0, 2) == 0) ? !fail_lvl : fail_lvl,
               $urandom_range(0, 99) == 0);
      end
      hold(0, 0, 0, 0, 2);
      settle();
      #2;
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
